// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
// State encoding, width helper and default frame width.
package uart_arb_pkg;

  localparam int PAYLOAD_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SENT,
    DRAIN
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority select: first set request at or
// after ptr, wrapping around.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  always_comb begin
    logic [IW:0]   s;
    logic [IW-1:0] j;
    s   = '0;
    j   = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= N_W) s = s - N_W;
      j = s[IW-1:0];
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx
// among N_REQ requesters, with stall and busy-rise timeouts.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int BUSY_RISE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic                          grant_valid,
  output logic [clog2(N_REQ)-1:0]       grant_id,
  output logic                          timeout_err
);

  localparam int IW = clog2(N_REQ);
  localparam int SW = clog2(LOCK_TIMEOUT + 1);
  localparam int BW = clog2(BUSY_RISE_MAX + 1);

  localparam logic [SW-1:0] STALL_MAX = SW'(LOCK_TIMEOUT);
  localparam logic [BW-1:0] RISE_LAST = BW'(BUSY_RISE_MAX - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_id;
  logic          pick_any;
  logic          last_q;
  logic          hs;
  logic [SW-1:0] stall;
  logic [BW-1:0] rise;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    req_ready = '0;
    req_ready[grant_id] = req_valid[grant_id]
                        & ~uart_tx_busy
                        & (state == GRANT);
  end

  assign hs      = req_ready[grant_id];
  assign next_id = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      grant_valid  <= 1'b0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      timeout_err  <= 1'b0;
      last_q       <= 1'b0;
      stall        <= '0;
      rise         <= '0;
    end else begin
      uart_tx_en  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            stall       <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            uart_tx_data <= req_data[grant_id*PAYLOAD_BITS +: PAYLOAD_BITS];
            last_q       <= req_last[grant_id];
            uart_tx_en   <= 1'b1;
            stall        <= '0;
            rise         <= '0;
            state        <= SENT;
          end else if (stall == STALL_MAX) begin
            timeout_err <= 1'b1;
            grant_valid <= 1'b0;
            ptr         <= next_id;
            state       <= IDLE;
          end else if (!req_valid[grant_id]) begin
            stall <= stall + 1'b1;
          end
        end
        SENT: begin
          if (uart_tx_busy) begin
            state <= DRAIN;
          end else if (rise == RISE_LAST) begin
            // transmitter never acknowledged; move on rather than hang
            timeout_err <= 1'b1;
            state       <= DRAIN;
          end else begin
            rise <= rise + 1'b1;
          end
        end
        DRAIN: begin
          if (!uart_tx_busy) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              ptr         <= next_id;
              state       <= IDLE;
            end else begin
              state <= GRANT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
